// File: rtl/ram_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ram_stream_reader                                                          |
// | Walks a wrapping address range on a block-RAM read port, emits valid/ready |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ram_stream_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  localparam logic [ADDR_WIDTH:0] c_max_len = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] c_one     = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [ADDR_WIDTH:0]   r_issue_left;
  logic [ADDR_WIDTH:0]   r_beat_left;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_buf [0:2];
  logic [1:0]            r_wptr;
  logic [1:0]            r_rptr;
  logic [1:0]            r_occ;
  logic                  r_busy;
  logic                  r_done;

  logic [2:0]            w_pending;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH:0]   w_len_clamped;

  function automatic logic [1:0] f_next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Issue decision uses only registered state, so m_ready never reaches raddr.
  assign w_pending     = {1'b0, r_occ} + {2'b00, r_inflight};
  assign w_issue       = (r_state == S_RUN) && (w_pending < 3'd3);
  assign w_push        = r_inflight;
  assign w_pop         = (r_occ != 2'd0) && m_ready;
  assign w_len_clamped = (len > c_max_len) ? c_max_len : len;

  assign raddr   = r_raddr;
  assign busy    = r_busy;
  assign done    = r_done;
  assign m_valid = (r_occ != 2'd0);
  assign m_data  = r_buf[r_rptr];
  assign m_last  = m_valid && (r_beat_left == c_one);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_raddr      <= '0;
      r_issue_left <= '0;
      r_beat_left  <= '0;
      r_inflight   <= 1'b0;
      r_wptr       <= 2'd0;
      r_rptr       <= 2'd0;
      r_occ        <= 2'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;

      if (w_push) begin
        r_buf[r_wptr] <= rdata;
        r_wptr        <= f_next_ptr(r_wptr);
      end
      if (w_pop) begin
        r_rptr      <= f_next_ptr(r_rptr);
        r_beat_left <= r_beat_left - c_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase

      if (w_issue) begin
        r_raddr      <= r_raddr + 1'b1;
        r_issue_left <= r_issue_left - c_one;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state      <= S_RUN;
              r_raddr      <= base_addr;
              r_issue_left <= w_len_clamped;
              r_beat_left  <= w_len_clamped;
              r_busy       <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_issue && (r_issue_left == c_one)) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop && (r_beat_left == c_one)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
`default_nettype none
// Bench for ram_stream_reader: table of transfers plus random ones, scored
// against a queue of expected words built straight from RAM contents.
module tb_ram_stream_reader;
  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int LIMIT = 4000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy, done;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;

  ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .raddr(raddr), .rdata(rdata),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) rdata <= mem[raddr];

  int total = 0;
  int bad = 0;
  int pat [8] = '{1, 0, 0, 1, 0, 1, 1, 0};

  typedef struct {
    logic [AW-1:0] base;
    int            len;
    int            mode;        // 0: always ready, 1: fixed pattern, 2: random
    int            restart_at;  // cycle of a second (ignored) start, 0 = none
    int            exp_n;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic ready_for(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return pat[k % 8] != 0;
    return $urandom_range(0, 99) < 60;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_raddr"}, raddr, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Called just after a rising edge; the start cycle is cycle 0.
  task automatic run_xfer(input logic [AW-1:0] b, input int l, input int mode,
                          input int restart_at, input int exp_n);
    logic [DW-1:0] q[$];
    logic [DW-1:0] e;
    logic [DW-1:0] prev_data;
    logic          prev_last, prev_stall;
    int eff, k, fin, nhs;
    eff = (l > DEPTH) ? DEPTH : l;
    for (int i = 0; i < eff; i++) q.push_back(mem[(int'(b) + i) % DEPTH]);

    start = 1'b1; base_addr = b; len = l[AW:0]; m_ready = ready_for(mode, 0);
    @(negedge clk);
    chk("busy_start_cycle", busy, 0);
    @(posedge clk); #1;
    start = 1'b0; base_addr = b ^ 10'h155; len = 11'd7;

    k = 1; fin = (eff == 0) ? 0 : -1; nhs = 0; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    while ((fin < 0 || k <= fin + 1) && k < LIMIT) begin
      m_ready = ready_for(mode, k);
      if (k == restart_at) begin
        start = 1'b1; base_addr = 10'h300; len = 11'd5;
      end
      @(negedge clk);
      chk("busy", busy, (eff > 0) && (fin < 0 || k <= fin));
      chk("done", done, (fin >= 0) && (k == fin + 1));
      if (k < 3 || (fin >= 0 && k > fin)) chk("valid_idle", m_valid, 0);
      if (eff > 0 && k == 1) chk("raddr_first", raddr, b);
      if (mode == 0) begin
        chk("valid_flow", m_valid, (k >= 3) && (k <= eff + 2));
        if (k <= eff) chk("raddr_seq", raddr, (int'(b) + k - 1) % DEPTH);
      end
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
        chk("stall_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          chk("extra_word", nhs + 1, eff);
        end else begin
          e = q.pop_front();
          chk("data", m_data, e);
          chk("last", m_last, q.size() == 0);
          nhs++;
          if (q.size() == 0) fin = k;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      @(posedge clk); #1;
      start = 1'b0;
      k++;
    end
    if (k >= LIMIT) chk("timeout", k, 0);
    chk("word_count", nhs, exp_n);
  endtask

  initial begin
    vecs[0] = '{10'h010,    4, 0, 0,    4};  // nominal
    vecs[1] = '{10'h010,    8, 1, 0,    8};  // backpressure pattern
    vecs[2] = '{10'h3FE,    4, 0, 0,    4};  // address wrap
    vecs[3] = '{10'h000,    0, 0, 0,    0};  // zero length
    vecs[4] = '{10'h000, 1500, 0, 0, 1024};  // overlong clamps
    vecs[5] = '{10'h010,    4, 0, 2,    4};  // start while busy
    vecs[6] = '{10'h000, 1024, 0, 0, 1024};  // full sweep
    vecs[7] = '{10'h3FF,    1, 1, 0,    1};
    vecs[8] = '{10'h3F0,   37, 2, 0,   37};
    vecs[9] = '{10'h200, 1024, 2, 0, 1024};

    for (int a = 0; a < DEPTH; a++) mem[a] = a[DW-1:0];

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_xfer(vecs[i].base, vecs[i].len, vecs[i].mode, vecs[i].restart_at, vecs[i].exp_n);
    end

    // Asynchronous reset in cycle 5 of a transfer, then a clean restart.
    start = 1'b1; base_addr = 10'h010; len = 11'd8; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_xfer(10'h020, 2, 0, 0, 2);

    for (int a = 0; a < DEPTH; a++) mem[a] = DW'($urandom);
    for (int i = 0; i < 20; i++) begin
      logic [AW-1:0] rb;
      int rl, rm;
      rb = AW'($urandom_range(0, DEPTH - 1));
      rl = (i % 7 == 6) ? $urandom_range(1025, 1400) : $urandom_range(0, 40);
      rm = $urandom_range(0, 2);
      run_xfer(rb, rl, rm, (i % 3 == 0) ? 2 : 0, (rl > DEPTH) ? DEPTH : rl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
